// File: rtl/store_stream_checker_pkg.sv
// Shared types for the store stream checker: FSM states and error codes.
package store_stream_checker_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } chk_state_t;

  typedef enum logic [2:0] {
    ERR_NONE    = 3'd0,
    ERR_DATA    = 3'd1,
    ERR_ADDR    = 3'd2,
    ERR_TIMEOUT = 3'd3
  } chk_err_t;

  // Entry-count width: enough to hold the value DEPTH itself.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/store_match_cam.sv
// Expected-store table: DEPTH valid/addr/data entries with a combinational
// lowest-index address search and a direct read port at rd_idx.
module store_match_cam
  import store_stream_checker_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_idx,
  input  logic [XLEN-1:0]          wr_addr,
  input  logic [XLEN-1:0]          wr_data,
  input  logic                     clr_en,
  input  logic [$clog2(DEPTH)-1:0] clr_idx,
  input  logic [XLEN-1:0]          srch_addr,
  input  logic [XLEN-1:0]          srch_data,
  output logic                     hit,
  output logic [$clog2(DEPTH)-1:0] hit_idx,
  output logic                     data_eq,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic                     rd_valid,
  output logic [XLEN-1:0]          rd_addr,
  output logic [XLEN-1:0]          rd_data
);

  localparam int IW = $clog2(DEPTH);

  logic [DEPTH-1:0]           valid;
  logic [DEPTH-1:0][XLEN-1:0] addr_q;
  logic [DEPTH-1:0][XLEN-1:0] data_q;

  // Valid bits: set on load, cleared on match, wiped by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en)  valid[wr_idx]  <= 1'b1;
      if (clr_en) valid[clr_idx] <= 1'b0;
    end
  end

  // Entry payload; meaningless while the valid bit is clear, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      addr_q[wr_idx] <= wr_addr;
      data_q[wr_idx] <= wr_data;
    end
  end

  // Address search; scanning high-to-low leaves the lowest matching index.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (valid[i] && addr_q[i] == srch_addr) begin
        hit     = 1'b1;
        hit_idx = IW'(i);
      end
    end
    data_eq = hit && (data_q[hit_idx] == srch_data);
  end

  assign rd_valid = valid[rd_idx];
  assign rd_addr  = addr_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/store_stream_checker.sv
// Watches the core's data-memory write port and checks each store against a
// preloaded table of expected (address, data) pairs, in load order or any
// order, with a RUN-cycle timeout and a sticky pass/fail verdict.
module store_stream_checker
  import store_stream_checker_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 20000,
  parameter int ORDERED = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     exp_valid,
  output logic                     exp_ready,
  input  logic [XLEN-1:0]          exp_addr,
  input  logic [XLEN-1:0]          exp_data,
  input  logic                     start,
  input  logic                     mem_we,
  input  logic [XLEN-1:0]          mem_addr,
  input  logic [XLEN-1:0]          mem_wdata,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic [2:0]               err_code,
  output logic [XLEN-1:0]          err_addr,
  output logic [XLEN-1:0]          err_data,
  output logic [$clog2(DEPTH):0]   match_count
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  chk_state_t      state, state_n;
  chk_err_t        err_q, err_n;
  logic            err_set;
  logic [XLEN-1:0] err_a_n, err_d_n;

  logic [IW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   loaded, loaded_inc, mcnt;
  logic [TW-1:0]   cyc_cnt;

  logic            load_fire, in_run, store_ev;
  logic            cmp_hit, cmp_eq, match_ok, all_done, tmo;
  logic [IW-1:0]   clr_idx;

  logic            hit, data_eq, rd_valid;
  logic [IW-1:0]   hit_idx;
  logic [XLEN-1:0] rd_addr, rd_data;

  assign load_fire  = (state == IDLE) && exp_valid && exp_ready;
  assign loaded_inc = loaded + CW'(load_fire);
  assign in_run     = (state == RUN);
  assign store_ev   = in_run && mem_we;

  store_match_cam #(.XLEN(XLEN), .DEPTH(DEPTH)) u_cam (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (load_fire),
    .wr_idx    (wr_ptr),
    .wr_addr   (exp_addr),
    .wr_data   (exp_data),
    .clr_en    (match_ok),
    .clr_idx   (clr_idx),
    .srch_addr (mem_addr),
    .srch_data (mem_wdata),
    .hit       (hit),
    .hit_idx   (hit_idx),
    .data_eq   (data_eq),
    .rd_idx    (rd_ptr),
    .rd_valid  (rd_valid),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data)
  );

  // Ordered mode checks only the head entry; any-order mode uses the search.
  always_comb begin
    cmp_hit = 1'b0;
    cmp_eq  = 1'b0;
    clr_idx = '0;
    if (ORDERED != 0) begin
      cmp_hit = rd_valid && (rd_addr == mem_addr);
      cmp_eq  = cmp_hit && (rd_data == mem_wdata);
      clr_idx = rd_ptr;
    end else begin
      cmp_hit = hit;
      cmp_eq  = data_eq;
      clr_idx = hit_idx;
    end
  end

  assign match_ok = store_ev && cmp_eq;
  assign all_done = match_ok && ((mcnt + CW'(1)) == loaded);
  assign tmo      = in_run && (cyc_cnt == TW'(TIMEOUT - 1));

  // Next state and error capture; a completing match beats a same-cycle
  // timeout, and a bad store is reported ahead of the timeout.
  always_comb begin
    state_n = state;
    err_set = 1'b0;
    err_n   = ERR_NONE;
    err_a_n = '0;
    err_d_n = '0;
    case (state)
      IDLE: begin
        if (start) state_n = (loaded_inc == '0) ? PASS : RUN;
      end
      RUN: begin
        if (all_done) begin
          state_n = PASS;
        end else if (store_ev && !cmp_eq) begin
          state_n = FAIL;
          err_set = 1'b1;
          err_n   = cmp_hit ? ERR_DATA : ERR_ADDR;
          err_a_n = mem_addr;
          err_d_n = mem_wdata;
        end else if (tmo) begin
          state_n = FAIL;
          err_set = 1'b1;
          err_n   = ERR_TIMEOUT;
        end
      end
      default: state_n = state;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Load pointers, match bookkeeping, cycle counter and error capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      loaded    <= '0;
      mcnt      <= '0;
      cyc_cnt   <= '0;
      exp_ready <= 1'b1;
      err_q     <= ERR_NONE;
      err_addr  <= '0;
      err_data  <= '0;
    end else begin
      if (load_fire) begin
        wr_ptr <= wr_ptr + IW'(1);
        loaded <= loaded_inc;
      end
      exp_ready <= (state_n == IDLE) && (loaded_inc < CW'(DEPTH));
      if (state == IDLE && start) cyc_cnt <= '0;
      else if (in_run)            cyc_cnt <= cyc_cnt + TW'(1);
      if (match_ok) begin
        mcnt   <= mcnt + CW'(1);
        rd_ptr <= rd_ptr + IW'(1);
      end
      if (err_set) begin
        err_q    <= err_n;
        err_addr <= err_a_n;
        err_data <= err_d_n;
      end
    end
  end

  assign pass        = (state == PASS);
  assign fail        = (state == FAIL);
  assign done        = pass | fail;
  assign err_code    = err_q;
  assign match_count = mcnt;

endmodule

// File: tb/tb_store_stream_checker.sv
// Scoreboard bench: an ordered and an any-order checker share stimulus; each
// scenario pushes the expected verdict (with its due cycle) per instance and
// a negedge monitor pops and compares when that instance's done rises.
module tb_store_stream_checker;

  localparam int XLEN = 32;
  localparam int DEPTH = 8;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic exp_valid = 1'b0, start = 1'b0, mem_we = 1'b0;
  logic [XLEN-1:0] exp_addr = '0, exp_data = '0, mem_addr = '0, mem_wdata = '0;

  logic [1:0] exp_ready, done, pass, fail;
  logic [2:0] err_code [2];
  logic [XLEN-1:0] err_addr [2];
  logic [XLEN-1:0] err_data [2];
  logic [CW-1:0] match_count [2];

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  store_stream_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(50), .ORDERED(1)) u_ord (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(exp_ready[0]),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done[0]), .pass(pass[0]),
    .fail(fail[0]), .err_code(err_code[0]), .err_addr(err_addr[0]),
    .err_data(err_data[0]), .match_count(match_count[0]));

  store_stream_checker #(.XLEN(XLEN), .DEPTH(DEPTH), .TIMEOUT(50), .ORDERED(0)) u_any (
    .clk(clk), .rst(rst), .exp_valid(exp_valid), .exp_ready(exp_ready[1]),
    .exp_addr(exp_addr), .exp_data(exp_data), .start(start), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .done(done[1]), .pass(pass[1]),
    .fail(fail[1]), .err_code(err_code[1]), .err_addr(err_addr[1]),
    .err_data(err_data[1]), .match_count(match_count[1]));

  typedef struct {
    logic [2:0]      code;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] data;
    logic [CW-1:0]   mcnt;
    int              due;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic push(input int d, input logic [2:0] code, input logic [31:0] a,
                      input logic [31:0] v, input int mc, input int due);
    exp_t e;
    e.code = code; e.addr = a; e.data = v; e.mcnt = CW'(mc); e.due = due;
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check_verdict(input int d);
    exp_t e;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL dut%0d_unexpected_verdict: got pass=%0d code=%0d, expected none",
               d, pass[d], err_code[d]);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("dut%0d_pass", d), 32'(pass[d]), 32'(e.code == 3'd0));
    chk($sformatf("dut%0d_fail", d), 32'(fail[d]), 32'(e.code != 3'd0));
    chk($sformatf("dut%0d_err_code", d), 32'(err_code[d]), 32'(e.code));
    chk($sformatf("dut%0d_err_addr", d), err_addr[d], e.addr);
    chk($sformatf("dut%0d_err_data", d), err_data[d], e.data);
    chk($sformatf("dut%0d_match_count", d), 32'(match_count[d]), 32'(e.mcnt));
    chk($sformatf("dut%0d_verdict_cycle", d), 32'(cyc), 32'(e.due));
  endtask

  // Monitor: compare against the scoreboard on each rising done.
  logic [1:0] done_q = 2'b00;
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++)
      if (done[d] && !done_q[d]) check_verdict(d);
    done_q = done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    exp_valid = 0; start = 0; mem_we = 0;
    rst = 1;
    tick();
    tick();
    rst = 0;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_exp_ready%0d", d), 32'(exp_ready[d]), 1);
      chk($sformatf("rst_done%0d", d), 32'(done[d]), 0);
      chk($sformatf("rst_pass%0d", d), 32'(pass[d]), 0);
      chk($sformatf("rst_fail%0d", d), 32'(fail[d]), 0);
      chk($sformatf("rst_err_code%0d", d), 32'(err_code[d]), 0);
      chk($sformatf("rst_err_addr%0d", d), err_addr[d], 0);
      chk($sformatf("rst_err_data%0d", d), err_data[d], 0);
      chk($sformatf("rst_match_count%0d", d), 32'(match_count[d]), 0);
    end
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] v);
    exp_valid = 1; exp_addr = a; exp_data = v;
    tick();
    exp_valid = 0;
  endtask

  task automatic do_start(output int c);
    start = 1; c = cyc;
    tick();
    start = 0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v, output int c);
    mem_we = 1; mem_addr = a; mem_wdata = v; c = cyc;
    tick();
    mem_we = 0;
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < maxc) begin
      tick();
      n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL verdict_wait: %0d/%0d verdicts still pending after %0d cycles",
               q0.size(), q1.size(), maxc);
      q0.delete();
      q1.delete();
    end
  endtask

  initial begin
    int c, s;

    // Ordered pass, back-to-back stores.
    reset_dut();
    load(96, 7); load(100, 25);
    do_start(s);
    store(96, 7, c);
    store(100, 25, c);
    push(0, 0, 0, 0, 2, c + 1);
    push(1, 0, 0, 0, 2, c + 1);
    drain(10);
    store(5, 5, c);  // ignored once verdict is in
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("hold_pass%0d", d), 32'(pass[d]), 1);
      chk($sformatf("hold_code%0d", d), 32'(err_code[d]), 0);
    end

    // Data mismatch.
    reset_dut();
    load(96, 7); load(100, 25);
    do_start(s);
    store(96, 8, c);
    push(0, 1, 96, 8, 0, c + 1);
    push(1, 1, 96, 8, 0, c + 1);
    drain(10);

    // Out-of-order arrival: ordered fails on first store, any-order passes.
    reset_dut();
    load(96, 7); load(100, 25);
    do_start(s);
    store(100, 25, c);
    push(0, 2, 100, 25, 0, c + 1);
    store(96, 7, c);
    push(1, 0, 0, 0, 2, c + 1);
    drain(10);

    // Timeout after 50 RUN cycles with no stores.
    reset_dut();
    load(96, 7);
    do_start(s);
    push(0, 3, 0, 0, 0, s + 51);
    push(1, 3, 0, 0, 0, s + 51);
    drain(80);

    // Final match on the last RUN cycle wins over timeout.
    reset_dut();
    load(96, 7);
    do_start(s);
    repeat (49) tick();
    store(96, 7, c);
    push(0, 0, 0, 0, 1, s + 51);
    push(1, 0, 0, 0, 1, s + 51);
    drain(10);

    // Table full: exp_ready drops after DEPTH loads, extra loads ignored.
    reset_dut();
    for (int i = 0; i < DEPTH + 2; i++) begin
      exp_valid = 1; exp_addr = 32'(200 + 4 * i); exp_data = 32'(3 * i + 1);
      tick();
      if (i == DEPTH - 2) chk("exp_ready_before_full", 32'(exp_ready[0]), 1);
      if (i == DEPTH - 1) begin
        chk("exp_ready_full_ord", 32'(exp_ready[0]), 0);
        chk("exp_ready_full_any", 32'(exp_ready[1]), 0);
      end
    end
    exp_valid = 0;
    do_start(s);
    for (int i = 0; i < DEPTH; i++) store(32'(200 + 4 * i), 32'(3 * i + 1), c);
    push(0, 0, 0, 0, DEPTH, c + 1);
    push(1, 0, 0, 0, DEPTH, c + 1);
    drain(10);

    // Empty table: start goes straight to pass.
    reset_dut();
    do_start(s);
    push(0, 0, 0, 0, 0, s + 1);
    push(1, 0, 0, 0, 0, s + 1);
    drain(10);

    // Reset mid-run discards table and progress.
    reset_dut();
    load(96, 7); load(100, 25);
    do_start(s);
    store(96, 7, c);
    chk("midrun_match_ord", 32'(match_count[0]), 1);
    chk("midrun_match_any", 32'(match_count[1]), 1);
    reset_dut();
    do_start(s);
    push(0, 0, 0, 0, 0, s + 1);
    push(1, 0, 0, 0, 0, s + 1);
    drain(10);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
